// File: rtl/cvm300_pixel_packer_pkg.sv
// Shared constants for the CVM300 capture path: FSM encoding, sensor geometry, byte lanes.
// Latency/backpressure: n/a (package only).
package cvm300_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int SENSOR_COLS       = 648;
  localparam int SENSOR_ROWS       = 488;
  localparam int FRAME_PIXELS_FULL = SENSOR_COLS * SENSOR_ROWS;

  // Only the top BYTE_W bits of each pixel are stored; LANES bytes make one FIFO word.
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;

endpackage

// File: rtl/cvm300_pixel_packer_if.sv
// Sensor-side and FIFO-write-side signals of the pixel packer.
// master = packer (drives FRAME_REQ and the FIFO write port), slave = sensor/FIFO side.
interface cvm300_pixel_packer_if #(
  parameter int PIX_W = 10
);
  logic             LVAL;
  logic             DVAL;
  logic [PIX_W-1:0] pixel;
  logic             fifo_full;
  logic             FRAME_REQ;
  logic [31:0]      fifo_din;
  logic             fifo_wr_en;

  modport master (input LVAL, DVAL, pixel, fifo_full, output FRAME_REQ, fifo_din, fifo_wr_en);
  modport slave  (output LVAL, DVAL, pixel, fifo_full, input FRAME_REQ, fifo_din, fifo_wr_en);
endinterface

// File: rtl/cvm300_pixel_packer_word_packer.sv
// Packs four bytes into one word, first byte in lane 0; word_vld pulses 1 clock after the 4th byte.
// No backpressure: the caller decides whether the presented word is written or dropped.
module pixel_word_packer
  import cvm300_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              pix_vld,
  input  logic [BYTE_W-1:0] pix_byte,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  logic [1:0]                    idx;
  logic [(LANES-1)*BYTE_W-1:0]   pack_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= 2'd0;
      pack_q   <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        idx    <= 2'd0;
        pack_q <= '0;
      end else if (pix_vld) begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0: pack_q[0*BYTE_W +: BYTE_W] <= pix_byte;
          2'd1: pack_q[1*BYTE_W +: BYTE_W] <= pix_byte;
          2'd2: pack_q[2*BYTE_W +: BYTE_W] <= pix_byte;
          default: begin
            // Completed word is latched separately so lane 0 can refill next cycle.
            word_vld <= 1'b1;
            word_dat <= {pix_byte, pack_q};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cvm300_pixel_packer.sv
// Requests one CVM300 frame, keeps the 8 MSBs of each valid pixel and writes packed 32-bit words.
// Write issues 1 clock after every 4th pixel; a full FIFO drops that word and sets overflow.
module cvm300_pixel_packer
  import cvm300_pkg::*;
#(
  parameter int PIX_W          = 10,
  parameter int FRAME_PIXELS   = FRAME_PIXELS_FULL,
  parameter int REQ_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
)(
  input  logic                 CLK_OUT,
  input  logic                 RES_N,
  input  logic                 start,
  cvm300_pixel_packer_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 timeout,
  output logic [18:0]          pixel_count,
  output logic [9:0]           line_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;

  logic [2:0]        state;
  logic              start_q;
  logic              lval_q;
  logic [TW-1:0]     tmo_cnt;
  logic [RW-1:0]     req_cnt;
  logic [WORD_W-1:0] din_hold;
  logic [WORD_W-1:0] word_dat;
  logic              word_vld;
  logic              trig;
  logic              accept;

  assign trig   = start & ~start_q & ((state == ST_IDLE) || (state == ST_DONE));
  // The first valid pixel is taken while still in WAIT; saturation stops any pixel past the frame.
  assign accept = ((state == ST_WAIT) || (state == ST_CAPTURE)) && bus.LVAL && bus.DVAL &&
                  (pixel_count < 19'(FRAME_PIXELS));

  assign busy           = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_CAPTURE);
  assign bus.FRAME_REQ  = (state == ST_REQ);
  assign bus.fifo_wr_en = word_vld & ~bus.fifo_full;
  assign bus.fifo_din   = bus.fifo_wr_en ? word_dat : din_hold;

  pixel_word_packer u_pack (
    .clk      (CLK_OUT),
    .rst_n    (RES_N),
    .clear    (trig),
    .pix_vld  (accept),
    .pix_byte (bus.pixel[PIX_W-1 -: BYTE_W]),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_ff @(posedge CLK_OUT) begin
    if (!RES_N) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      lval_q      <= 1'b0;
      tmo_cnt     <= '0;
      req_cnt     <= '0;
      din_hold    <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      pixel_count <= '0;
      line_count  <= '0;
    end else begin
      start_q <= start;
      lval_q  <= bus.LVAL;
      if (bus.fifo_wr_en)
        din_hold <= word_dat;
      if (word_vld && bus.fifo_full)
        overflow <= 1'b1;
      if (accept)
        pixel_count <= pixel_count + 19'd1;
      if ((state == ST_CAPTURE) && lval_q && !bus.LVAL)
        line_count <= line_count + 10'd1;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (trig) begin
            pixel_count <= '0;
            line_count  <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
            req_cnt     <= '0;
            tmo_cnt     <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_cnt == RW'(REQ_CYCLES - 1))
            state <= ST_WAIT;
          else
            req_cnt <= req_cnt + 1'b1;
        end
        ST_WAIT: begin
          if (accept) begin
            state <= ST_CAPTURE;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          // Count hits the frame size exactly in the cycle the last word is presented.
          if (pixel_count == 19'(FRAME_PIXELS)) begin
            frame_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cvm300_pixel_packer.sv
// Directed/random bench for cvm300_pixel_packer built with a 16-pixel frame and 100-clock timeout.
// Expected words, write cycles and counters come from a pixel-list reference model.
module tb_cvm300_pixel_packer;

  localparam int FP = 16;
  localparam int TO = 100;
  localparam int RQ = 2;

  logic        CLK_OUT = 1'b0;
  logic        RES_N   = 1'b0;
  logic        start   = 1'b0;
  logic        busy, frame_done, overflow, timeout;
  logic [18:0] pixel_count;
  logic [9:0]  line_count;

  cvm300_pixel_packer_if #(.PIX_W(10)) bus ();

  cvm300_pixel_packer #(
    .PIX_W(10), .FRAME_PIXELS(FP), .REQ_CYCLES(RQ), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_OUT     (CLK_OUT),
    .RES_N       (RES_N),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .timeout     (timeout),
    .pixel_count (pixel_count),
    .line_count  (line_count)
  );

  always #5 CLK_OUT = ~CLK_OUT;

  int cyc = 0;
  always @(posedge CLK_OUT) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_dat[$];
  int          got_cyc[$];
  always @(negedge CLK_OUT)
    if (bus.fifo_wr_en === 1'b1) begin
      got_dat.push_back(bus.fifo_din);
      got_cyc.push_back(cyc);
    end

  // Reference model: accepted pixel list folded into words, one write per 4 pixels.
  logic [31:0] exp_dat[$];
  int          exp_cyc[$];
  int          m_cnt, m_lines, drop_word;
  bit          m_armed, m_capt, m_done, m_ovf, m_pend, m_lv_prev;
  logic [31:0] m_acc, m_word, m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_OUT);
    #1;
  endtask

  task automatic model_clear();
    exp_dat.delete(); exp_cyc.delete(); got_dat.delete(); got_cyc.delete();
    m_cnt = 0; m_lines = 0; m_armed = 0; m_capt = 0; m_done = 0; m_ovf = 0;
    m_pend = 0; m_acc = '0; m_word = '0; drop_word = -1;
  endtask

  task automatic do_reset(input int n);
    RES_N = 1'b0; start = 1'b0;
    bus.LVAL = 1'b0; bus.DVAL = 1'b0; bus.pixel = '0; bus.fifo_full = 1'b0;
    repeat (n) tick();
    RES_N = 1'b1;
    m_lv_prev = 1'b0; m_last = '0;
    model_clear();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, bus.FRAME_REQ, 0);
    chk({tag, "_wr_en"}, bus.fifo_wr_en, 0);
    chk({tag, "_din"}, bus.fifo_din, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_tmo"}, timeout, 0);
    chk({tag, "_pcnt"}, pixel_count, 0);
    chk({tag, "_lcnt"}, line_count, 0);
  endtask

  task automatic trigger(input string tag);
    model_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_req0"}, bus.FRAME_REQ, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done_clr"}, frame_done, 0);
    chk({tag, "_pcnt_clr"}, pixel_count, 0);
    tick();
    chk({tag, "_req1"}, bus.FRAME_REQ, 1);
    tick();
    chk({tag, "_req_fall"}, bus.FRAME_REQ, 0);
    m_armed = 1;
  endtask

  // One clock of sensor/FIFO stimulus; the model applies the spec rules for this cycle.
  task automatic cycle(input bit lv, input bit dv, input logic [9:0] p, input bit full_arg);
    bit eff_full;
    eff_full = m_pend ? ((m_cnt / 4) == drop_word) : full_arg;
    bus.LVAL = lv; bus.DVAL = dv; bus.pixel = p; bus.fifo_full = eff_full;
    if (m_capt && m_lv_prev && !lv) m_lines++;
    if (m_pend) begin
      m_pend = 0;
      if (eff_full) begin
        m_ovf = 1;
        @(negedge CLK_OUT);
        chk("drop_wr_en", bus.fifo_wr_en, 0);
        chk("drop_din_hold", bus.fifo_din, m_last);
      end else begin
        exp_dat.push_back(m_word);
        exp_cyc.push_back(cyc);
        m_last = m_word;
      end
      if (m_cnt == FP) begin m_capt = 0; m_done = 1; end
    end
    if (m_armed && !m_done && lv && dv && m_cnt < FP) begin
      m_capt = 1;
      if (m_cnt % 4 == 0) m_acc = '0;
      m_acc = m_acc | (32'(p >> 2) << (8 * (m_cnt % 4)));
      m_cnt++;
      if (m_cnt % 4 == 0) begin m_pend = 1; m_word = m_acc; end
    end
    m_lv_prev = lv;
    tick();
  endtask

  task automatic feed_line(input int n, input bit gaps, input bit rfull, input int tail);
    int sent;
    sent = 0;
    while (sent < n) begin
      if (gaps && $urandom_range(0, 3) == 0)
        cycle(1'b1, 1'b0, 10'($urandom_range(0, 1023)), rfull && $urandom_range(0, 1) == 1);
      else begin
        cycle(1'b1, 1'b1, 10'($urandom_range(0, 1023)), rfull && $urandom_range(0, 1) == 1);
        sent++;
      end
    end
    repeat (tail) cycle(1'b0, 1'b0, 10'd0, rfull && $urandom_range(0, 1) == 1);
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwr"}, got_dat.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      chk($sformatf("%s_dat%0d", tag, i), got_dat[i], exp_dat[i]);
      chk($sformatf("%s_cyc%0d", tag, i), got_cyc[i], exp_cyc[i]);
    end
    chk({tag, "_pcnt"}, pixel_count, m_cnt);
    chk({tag, "_lcnt"}, line_count, m_lines);
    chk({tag, "_done"}, frame_done, m_done);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_busy"}, busy, m_armed && !m_done);
    chk({tag, "_din_hold"}, bus.fifo_din, m_last);
  endtask

  logic [9:0] basic_pix[4] = '{10'h004, 10'h008, 10'h00C, 10'h010};

  initial begin
    // Reset and idle
    do_reset(3);
    chk_all_zero("rst");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_req%0d", i), bus.FRAME_REQ, 0);
    end
    chk("idle_nwr", got_dat.size(), 0);

    // Basic pack, back-to-back pixels
    trigger("basic");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, basic_pix[i], 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 10'd0, 1'b0);
    cmp_writes("basic");
    chk("basic_word", got_dat.size() > 0 ? got_dat[0] : 32'hDEAD_BEEF, 32'h0403_0201);

    // Same pixels with DVAL gaps carrying junk data
    do_reset(1);
    trigger("gaps");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, basic_pix[i], 1'b0);
      cycle(1'b1, 1'b0, 10'h3FF, 1'b0);
    end
    repeat (2) cycle(1'b0, 1'b0, 10'd0, 1'b0);
    cmp_writes("gaps");
    chk("gaps_word", got_dat.size() > 0 ? got_dat[0] : 32'hDEAD_BEEF, 32'h0403_0201);
    chk("gaps_pcnt4", pixel_count, 4);

    // Full frame: 2 lines of 8 random pixels, FIFO full only outside write cycles, then an extra line
    do_reset(1);
    trigger("frame");
    feed_line(8, 1'b1, 1'b1, 3);
    feed_line(8, 1'b1, 1'b1, 3);
    feed_line(4, 1'b0, 1'b0, 2);
    cmp_writes("frame");
    chk("frame_nwr4", got_dat.size(), 4);
    chk("frame_lines2", line_count, 2);
    chk("frame_done1", frame_done, 1);
    chk("frame_idle", busy, 0);

    // Overflow: restart from DONE, FIFO full while the 2nd word is presented
    trigger("ovf");
    drop_word = 2;
    feed_line(8, 1'b0, 1'b0, 2);
    feed_line(8, 1'b0, 1'b0, 2);
    cmp_writes("ovf");
    chk("ovf_nwr3", got_dat.size(), 3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_pcnt16", pixel_count, 16);

    // Timeout: no DVAL after the request; counter runs from the end of FRAME_REQ
    trigger("tmo");
    repeat (TO - 1) cycle(1'($urandom_range(0, 1)), 1'b0, 10'($urandom_range(0, 1023)), 1'b0);
    chk("tmo_early", timeout, 0);
    chk("tmo_busy", busy, 1);
    cycle(1'b0, 1'b0, 10'd0, 1'b0);
    chk("tmo_set", timeout, 1);
    chk("tmo_done0", frame_done, 0);
    chk("tmo_idle", busy, 0);
    chk("tmo_lcnt", line_count, 0);
    chk("tmo_nwr", got_dat.size(), 0);

    // Abort: reset arrives together with the 4th pixel of a word
    do_reset(1);
    trigger("abort");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, basic_pix[i], 1'b0);
    RES_N = 1'b0;
    bus.LVAL = 1'b1; bus.DVAL = 1'b1; bus.pixel = basic_pix[3];
    tick();
    chk_all_zero("abort");
    RES_N = 1'b1;
    bus.LVAL = 1'b0; bus.DVAL = 1'b0;
    repeat (4) tick();
    chk("abort_nwr", got_dat.size(), 0);
    chk("abort_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
